sector_write_responder: RTL and testbench
=========================================

# sector_write_responder

AVMM write responder at the far end of the sector write path. It accepts translated sector writes on a waitrequest-flow-controlled AVMM slave and buffers them in a small FIFO. It then presents them to the sector configuration logic as a valid/ready stream of {slot, data}. Writes to addresses outside the sector window, including the drop address, are absorbed and counted as security errors; they are never forwarded.

## Interface
- DATA_SIZE, 32, write data width
- AVMM_ADDR_SIZE, 16, AVMM address width
- BASE_ADDR, 'h0000, AVMM address of slot 0
- NUM_SLOTS, 9, number of valid slots (2..16)
- DROP_ADDR, 'hffff, drop address; always illegal even if inside the window
- FIFO_DEPTH, 4, buffer entries (power of 2, ≥2)

- clock_clk  in  1  single clock
- reset_reset  in  1  asynchronous, active-low reset
- avs_s0_address  in  AVMM_ADDR_SIZE  write address
- avs_s0_write  in  1  write strobe
- avs_s0_writedata  in  DATA_SIZE  write data
- avs_s0_waitrequest  out  1  stall; high while not ready or FIFO full
- sec_valid  out  1  FIFO head valid
- sec_ready  in  1  downstream accepts head
- sec_slot  out  4  slot index of head (address − BASE_ADDR)
- sec_data  out  DATA_SIZE  data of head
- avl_csr_write  in  1  CSR write
- avl_csr_read  in  1  CSR read
- avl_csr_addr  in  1  CSR select
- avl_csr_wrdata  in  32  CSR write data
- avl_csr_rddata  out  32  CSR read data, registered
- err_irq  out  1  security error indication

## Operation
- A write is accepted when avs_s0_write=1 and avs_s0_waitrequest=0. Each accepted write is decoded as follows:
  - Legal: BASE_ADDR ≤ address < BASE_ADDR+NUM_SLOTS and address ≠ DROP_ADDR. The block pushes {address−BASE_ADDR, data} and increments acc_count (16-bit, wraps).
  - Illegal: all other addresses. The write is discarded, err_count (16-bit) saturates at 'hffff, and err_sticky is set.
- avs_s0_waitrequest = ~ready_q | full, independent of the address.
  - ready_q is 0 in reset and becomes 1 on the first clock edge after reset deasserts.
- FIFO ordering:
  - Order is strict FIFO.
  - A pop occurs on sec_valid & sec_ready.
  - Push and pop in the same cycle leave the occupancy unchanged.
  - When full, no push is possible (waitrequest is high), even if a pop happens in the same cycle; there is no fall-through.
- Outputs: sec_valid = (count≠0). sec_slot and sec_data are driven from the head entry and stay stable while sec_valid=1 and sec_ready=0.
- CSR map (reads registered):
  - avl_csr_addr=0 reads {err_count, acc_count}.
  - avl_csr_addr=1 reads {29'b0, err_sticky, full, sec_valid}.
  - A write to avl_csr_addr=1 with wrdata[0]=1 clears err_sticky, err_count and acc_count.
  - If a clear and an accepted write occur in the same cycle, the clear applies first and the new event is then counted. Example: an illegal write alongside a clear leaves err_count=1 and err_sticky=1.
- Reset values:
  - waitrequest=1, sec_valid=0, sec_slot=0, sec_data=0, avl_csr_rddata=0, err_irq=0.
  - All counters and the sticky bit are 0; FIFO pointers are 0.
- Reset asserted mid-operation flushes the FIFO immediately. Entries in flight are lost, and no partial handshake completes.

## Timing
- Latency from an accepted legal write to sec_valid=1 (FIFO empty): 1 cycle.
- Throughput: 1 write/cycle sustained when sec_ready=1 continuously.
- waitrequest:
  - Rises in the cycle after the push that fills the FIFO.
  - Falls in the cycle after the first pop from full.
- CSR read data is valid 1 cycle after avl_csr_read.
- Counters and err_sticky update 1 cycle after the accepting edge.
- err_irq follows err_sticky with no extra delay.

## Configuration
- SECTOR_RESP_ERR_IRQ_EN defined: err_irq = err_sticky.
- SECTOR_RESP_ERR_IRQ_EN undefined: err_irq is tied 0. err_sticky, err_count and the CSR map are unchanged.

## Test plan
- Reset release, then write addr 'h0003, data 'hA5A5_0001 with sec_ready=1 -> waitrequest=0 on cycle 1 after release; sec_valid=1 one cycle after accept with sec_slot=3 and sec_data='hA5A5_0001; CSR0 = 'h0000_0001.
- sec_ready=0 with back-to-back writes to slots 0..4 (FIFO_DEPTH=4) -> 4 accepted, waitrequest=1 holding the 5th; then one sec_ready pulse -> slot 0 popped, 5th accepted, order 0,1,2,3,4 preserved.
- Writes to 'h0009, then 'hffff, then legal 'h0008 -> two errors, one push; CSR0 = 'h0002_0001; CSR1 bit2=1; err_irq=1 with the macro defined, 0 without.
- Same-cycle CSR clear and illegal write -> err_count=1, err_sticky=1, acc_count=0.
- Assert reset_reset low with 3 entries queued mid-handshake -> sec_valid=0 and waitrequest=1 asynchronously; after release the FIFO is empty and counters read 0.
- 'hffff illegal writes held for 65540 cycles -> err_count saturates at 'hffff and does not wrap.

Source files
------------

// File: rtl/sector_write_responder_if.sv
// Write-path bundle for sector_write_responder: AVMM write slave side and
// the {slot, data} valid/ready stream toward the sector configuration logic.
interface sector_write_responder_if #(
  parameter int DATA_SIZE      = 32,
  parameter int AVMM_ADDR_SIZE = 16
);
  logic [AVMM_ADDR_SIZE-1:0] avs_s0_address;
  logic                      avs_s0_write;
  logic [DATA_SIZE-1:0]      avs_s0_writedata;
  logic                      avs_s0_waitrequest;
  logic                      sec_valid;
  logic                      sec_ready;
  logic [3:0]                sec_slot;
  logic [DATA_SIZE-1:0]      sec_data;

  modport slave (
    input  avs_s0_address, avs_s0_write, avs_s0_writedata, sec_ready,
    output avs_s0_waitrequest, sec_valid, sec_slot, sec_data
  );

  modport master (
    output avs_s0_address, avs_s0_write, avs_s0_writedata, sec_ready,
    input  avs_s0_waitrequest, sec_valid, sec_slot, sec_data
  );
endinterface

// File: rtl/sector_write_responder.sv
// Sector write responder: buffers in-window AVMM writes as {slot, data} in a small FIFO,
// absorbs and counts out-of-window writes. Macro SECTOR_RESP_ERR_IRQ_EN drives err_irq from err_sticky.
module sector_write_responder #(
  parameter int DATA_SIZE      = 32,
  parameter int AVMM_ADDR_SIZE = 16,
  parameter int BASE_ADDR      = 'h0000,
  parameter int NUM_SLOTS      = 9,
  parameter int DROP_ADDR      = 'hffff,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                   clock_clk,
  input  logic                   reset_reset,
  sector_write_responder_if.slave s_bus,
  input  logic                   avl_csr_write,
  input  logic                   avl_csr_read,
  input  logic                   avl_csr_addr,
  input  logic [31:0]            avl_csr_wrdata,
  output logic [31:0]            avl_csr_rddata,
  output logic                   err_irq
);

  localparam int          LP_PW   = $clog2(FIFO_DEPTH);
  localparam logic [32:0] LP_LO   = 33'(BASE_ADDR);
  localparam logic [31:0] LP_DROP = 32'(DROP_ADDR);
  localparam logic [31:0] LP_NUM  = 32'(NUM_SLOTS);

  logic [DATA_SIZE+3:0] r_mem [FIFO_DEPTH];
  logic [LP_PW-1:0]     r_wr_ptr;
  logic [LP_PW-1:0]     r_rd_ptr;
  logic [LP_PW:0]       r_count;
  logic                 r_ready_q;
  logic [15:0]          r_acc_count;
  logic [15:0]          r_err_count;
  logic                 r_err_sticky;

  logic                 w_full;
  logic                 w_valid;
  logic                 w_accept;
  logic                 w_legal;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_clear;
  logic [32:0]          w_addr_off;
  logic [3:0]           w_slot;
  logic [DATA_SIZE+3:0] w_head;
  logic [15:0]          w_acc_next;
  logic [15:0]          w_err_next;
  logic                 w_sticky_next;
  logic                 w_unused;

  assign w_full   = (r_count == (LP_PW+1)'(FIFO_DEPTH));
  assign w_valid  = (r_count != '0);
  assign s_bus.avs_s0_waitrequest = ~r_ready_q | w_full;
  assign w_accept = s_bus.avs_s0_write & ~s_bus.avs_s0_waitrequest;

  // 33-bit offset: bit 32 set means the address lies below the window base.
  assign w_addr_off = {1'b0, 32'(s_bus.avs_s0_address)} - LP_LO;
  assign w_legal    = ~w_addr_off[32] && (w_addr_off[31:0] < LP_NUM)
                      && (32'(s_bus.avs_s0_address) != LP_DROP);
  assign w_slot     = w_addr_off[3:0];
  assign w_push     = w_accept & w_legal;
  assign w_pop      = w_valid & s_bus.sec_ready;
  assign w_clear    = avl_csr_write & avl_csr_addr & avl_csr_wrdata[0];
  assign w_unused   = ^avl_csr_wrdata[31:1];

  always_ff @(posedge clock_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {w_slot, s_bus.avs_s0_writedata};
    end
  end

  // Head is masked while empty so stale entries never reach the stream.
  assign w_head          = r_mem[r_rd_ptr];
  assign s_bus.sec_valid = w_valid;
  assign s_bus.sec_slot  = w_valid ? w_head[DATA_SIZE+3:DATA_SIZE] : 4'd0;
  assign s_bus.sec_data  = w_valid ? w_head[DATA_SIZE-1:0] : '0;

  always_ff @(posedge clock_clk or negedge reset_reset) begin
    if (!reset_reset) begin
      r_ready_q <= 1'b0;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
    end else begin
      r_ready_q <= 1'b1;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (w_pop && !w_push) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  // A clear wipes the old state first; an event in the same cycle then counts on top.
  always_comb begin
    w_acc_next    = w_clear ? 16'd0 : r_acc_count;
    w_err_next    = w_clear ? 16'd0 : r_err_count;
    w_sticky_next = w_clear ? 1'b0  : r_err_sticky;
    if (w_push) begin
      w_acc_next = w_acc_next + 16'd1;
    end
    if (w_accept && !w_legal) begin
      w_sticky_next = 1'b1;
      if (w_err_next != 16'hffff) begin
        w_err_next = w_err_next + 16'd1;
      end
    end
  end

  always_ff @(posedge clock_clk or negedge reset_reset) begin
    if (!reset_reset) begin
      r_acc_count    <= 16'd0;
      r_err_count    <= 16'd0;
      r_err_sticky   <= 1'b0;
      avl_csr_rddata <= 32'd0;
    end else begin
      r_acc_count  <= w_acc_next;
      r_err_count  <= w_err_next;
      r_err_sticky <= w_sticky_next;
      if (avl_csr_read) begin
        avl_csr_rddata <= avl_csr_addr ? {29'd0, r_err_sticky, w_full, w_valid}
                                       : {r_err_count, r_acc_count};
      end
    end
  end

`ifdef SECTOR_RESP_ERR_IRQ_EN
  assign err_irq = r_err_sticky;
`else
  assign err_irq = 1'b0;
`endif

endmodule

// File: tb/tb_sector_write_responder.sv
// Scoreboard bench for sector_write_responder: directed writes push expected
// {slot, data} into a queue that a negedge monitor checks on every stream handshake.
module tb_sector_write_responder;

  localparam bit EXP_IRQ =
`ifdef SECTOR_RESP_ERR_IRQ_EN
    1'b1;
`else
    1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        csr_write = 1'b0;
  logic        csr_read = 1'b0;
  logic        csr_addr = 1'b0;
  logic [31:0] csr_wrdata = 32'd0;
  logic [31:0] csr_rddata;
  logic        err_irq;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [35:0] exp_q[$];

  sector_write_responder_if #(.DATA_SIZE(32), .AVMM_ADDR_SIZE(16)) bus ();

  sector_write_responder dut (
    .clock_clk      (clk),
    .reset_reset    (rst_n),
    .s_bus          (bus),
    .avl_csr_write  (csr_write),
    .avl_csr_read   (csr_read),
    .avl_csr_addr   (csr_addr),
    .avl_csr_wrdata (csr_wrdata),
    .avl_csr_rddata (csr_rddata),
    .err_irq        (err_irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h required=%h", name, act, exp);
    end else begin
      $display("ok   %s = %h", name, act);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.sec_valid && bus.sec_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL pop_unexpected got slot=%0d data=%h required none",
                 bus.sec_slot, bus.sec_data);
      end else begin
        logic [35:0] e;
        e = exp_q.pop_front();
        check("pop_slot", 32'(bus.sec_slot), 32'(e[35:32]));
        check("pop_data", bus.sec_data, e[31:0]);
      end
    end
  end

  // Called just after a posedge; returns just after the accepting posedge with write still high.
  task automatic do_write(input logic [15:0] addr, input logic [31:0] data, input bit push_exp);
    bit done = 1'b0;
    bus.avs_s0_address   = addr;
    bus.avs_s0_writedata = data;
    bus.avs_s0_write     = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (!bus.avs_s0_waitrequest) begin
        done = 1'b1;
        if (push_exp) exp_q.push_back({addr[3:0], data});
      end
      @(posedge clk); #1;
    end
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL write_timeout addr=%h got waitrequest=1 required 0", addr);
    end
  endtask

  task automatic idle(input int n);
    bus.avs_s0_write = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic csr_rd(input logic a, output logic [31:0] v);
    csr_addr = a;
    csr_read = 1'b1;
    @(posedge clk); #1;
    csr_read = 1'b0;
    v = csr_rddata;
  endtask

  task automatic csr_clear();
    csr_addr   = 1'b1;
    csr_wrdata = 32'd1;
    csr_write  = 1'b1;
    @(posedge clk); #1;
    csr_write  = 1'b0;
    csr_wrdata = 32'd0;
  endtask

  task automatic drain();
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    check("drain_queue_left", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    logic [31:0] v;
    bus.avs_s0_address   = 16'd0;
    bus.avs_s0_write     = 1'b0;
    bus.avs_s0_writedata = 32'd0;
    bus.sec_ready        = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_waitrequest", 32'(bus.avs_s0_waitrequest), 32'd1);
    check("rst_sec_valid", 32'(bus.sec_valid), 32'd0);
    check("rst_sec_slot", 32'(bus.sec_slot), 32'd0);
    check("rst_sec_data", bus.sec_data, 32'd0);
    check("rst_rddata", csr_rddata, 32'd0);
    check("rst_err_irq", 32'(err_irq), 32'd0);

    // Release and first legal write
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("wait_before_edge1", 32'(bus.avs_s0_waitrequest), 32'd1);
    @(posedge clk); #1;
    check("wait_after_edge1", 32'(bus.avs_s0_waitrequest), 32'd0);
    bus.sec_ready = 1'b1;
    do_write(16'h0003, 32'hA5A5_0001, 1'b1);
    bus.avs_s0_write = 1'b0;
    check("latency_valid", 32'(bus.sec_valid), 32'd1);
    check("latency_slot", 32'(bus.sec_slot), 32'd3);
    idle(1);
    csr_rd(1'b0, v);
    check("csr0_after_one", v, 32'h0000_0001);

    // Fill FIFO with ready low, then a single ready pulse admits the 5th write
    bus.sec_ready = 1'b0;
    for (int s = 0; s < 4; s++) do_write(16'(s), 32'hB000_0000 + 32'(s), 1'b1);
    bus.avs_s0_address   = 16'h0004;
    bus.avs_s0_writedata = 32'hB000_0004;
    exp_q.push_back({4'd4, 32'hB000_0004});
    csr_addr = 1'b1;
    csr_read = 1'b1;
    @(negedge clk);
    check("full_waitrequest", 32'(bus.avs_s0_waitrequest), 32'd1);
    @(posedge clk); #1;
    csr_read = 1'b0;
    check("csr1_full", csr_rddata, 32'h0000_0003);
    bus.sec_ready = 1'b1;
    @(negedge clk);
    check("pop_edge_waitrequest", 32'(bus.avs_s0_waitrequest), 32'd1);
    @(posedge clk); #1;
    bus.sec_ready = 1'b0;
    @(negedge clk);
    check("after_pop_waitrequest", 32'(bus.avs_s0_waitrequest), 32'd0);
    @(posedge clk); #1;
    bus.avs_s0_write = 1'b0;
    @(negedge clk);
    check("refilled_waitrequest", 32'(bus.avs_s0_waitrequest), 32'd1);
    @(posedge clk); #1;
    bus.sec_ready = 1'b1;
    drain();

    // Illegal addresses absorbed, legal edge slot forwarded
    csr_clear();
    do_write(16'h0009, 32'hDEAD_0009, 1'b0);
    do_write(16'hffff, 32'hDEAD_FFFF, 1'b0);
    do_write(16'h0008, 32'hC0DE_0008, 1'b1);
    idle(2);
    drain();
    csr_rd(1'b0, v);
    check("csr0_errors", v, 32'h0002_0001);
    csr_rd(1'b1, v);
    check("csr1_sticky", v, 32'h0000_0004);
    check("err_irq", 32'(err_irq), 32'(EXP_IRQ));

    // Clear and illegal write in the same cycle
    csr_addr   = 1'b1;
    csr_wrdata = 32'd1;
    csr_write  = 1'b1;
    bus.avs_s0_address = 16'h0009;
    bus.avs_s0_write   = 1'b1;
    @(negedge clk);
    check("clear_edge_waitrequest", 32'(bus.avs_s0_waitrequest), 32'd0);
    @(posedge clk); #1;
    csr_write = 1'b0;
    csr_wrdata = 32'd0;
    bus.avs_s0_write = 1'b0;
    csr_rd(1'b0, v);
    check("csr0_clear_plus_err", v, 32'h0001_0000);
    csr_rd(1'b1, v);
    check("csr1_clear_plus_err", v, 32'h0000_0004);

    // Asynchronous reset with entries queued and a write pending
    bus.sec_ready = 1'b0;
    for (int s = 5; s < 8; s++) do_write(16'(s), 32'hE000_0000 + 32'(s), 1'b0);
    bus.avs_s0_address = 16'h0001;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_sec_valid", 32'(bus.sec_valid), 32'd0);
    check("async_waitrequest", 32'(bus.avs_s0_waitrequest), 32'd1);
    bus.avs_s0_write = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(2);
    check("post_rst_sec_valid", 32'(bus.sec_valid), 32'd0);
    csr_rd(1'b0, v);
    check("post_rst_csr0", v, 32'h0000_0000);
    csr_rd(1'b1, v);
    check("post_rst_csr1", v, 32'h0000_0000);

    // err_count saturation under sustained drop-address writes
    bus.sec_ready = 1'b1;
    bus.avs_s0_address = 16'hffff;
    bus.avs_s0_write   = 1'b1;
    repeat (65540) @(posedge clk);
    #1;
    bus.avs_s0_write = 1'b0;
    csr_rd(1'b0, v);
    check("csr0_saturated", v, 32'hffff_0000);
    check("sat_sec_valid", 32'(bus.sec_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
